// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO.
// Ports: clk, rst_n (async, active-low); mdu_op[3:0], mthilo[1:0],
//   mfhilo[1:0], rs_data[31:0], rt_data[31:0], exc_flush in;
//   busy, hilo_out[31:0], hi[31:0], lo[31:0] out.
// Macro MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (op 5-8).
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op,
  input  logic [1:0]  mthilo,
  input  logic [1:0]  mfhilo,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exc_flush,
  output logic        busy,
  output logic [31:0] hilo_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW =
    ($clog2(MAXC) < 4) ? 4 : $clog2(MAXC);
  localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [63:0]   res;
  logic [63:0]   res_nx;
  logic [31:0]   hi_nx;
  logic [31:0]   lo_nx;

  // ---- opcode decode
  logic op_mul;
  logic op_mulu;
  logic op_div;
  logic op_divu;
  logic is_div;
  logic sgn_mul;
  logic op_valid;
  logic start;

  assign op_mul  = (mdu_op == 4'd1);
  assign op_mulu = (mdu_op == 4'd2);
  assign op_div  = (mdu_op == 4'd3);
  assign op_divu = (mdu_op == 4'd4);
  assign is_div  = op_div | op_divu;

`ifdef MDU_MADD_EN
  logic op_madd;
  logic op_maddu;
  logic op_msub;
  logic op_msubu;
  logic is_acc;
  logic is_sub;

  assign op_madd  = (mdu_op == 4'd5);
  assign op_maddu = (mdu_op == 4'd6);
  assign op_msub  = (mdu_op == 4'd7);
  assign op_msubu = (mdu_op == 4'd8);
  assign is_sub   = op_msub | op_msubu;
  assign is_acc   = op_madd | op_maddu | is_sub;
  assign sgn_mul  = op_mul | op_madd | op_msub;
  assign op_valid = op_mul | op_mulu | is_div | is_acc;
`else
  assign sgn_mul  = op_mul;
  assign op_valid = op_mul | op_mulu | is_div;
`endif

  assign start = (state == IDLE) & op_valid & ~exc_flush;

  // ---- multiplier: sign-extend to 64 bits, low 64 of product
  logic [63:0] ma;
  logic [63:0] mb;
  logic [63:0] prod;

  assign ma   = {{32{sgn_mul & rs_data[31]}}, rs_data};
  assign mb   = {{32{sgn_mul & rt_data[31]}}, rt_data};
  assign prod = ma * mb;

  // ---- divider on magnitudes, signs restored afterwards.
  // Magnitude path covers 0x8000_0000 / -1 without overflow.
  logic        neg_a;
  logic        neg_b;
  logic        dz;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] dsr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;

  assign neg_a = op_div & rs_data[31];
  assign neg_b = op_div & rt_data[31];
  assign dz    = (rt_data == 32'd0);
  assign abs_a = neg_a ? -rs_data : rs_data;
  assign abs_b = neg_b ? -rt_data : rt_data;
  assign dsr   = dz ? 32'd1 : abs_b;
  assign uq    = abs_a / dsr;
  assign ur    = abs_a % dsr;

  always_comb begin
    quo = (neg_a ^ neg_b) ? -uq : uq;
    rem = neg_a ? -ur : ur;
    if (dz) begin
      quo = 32'hFFFF_FFFF;
      rem = rs_data;
    end
  end

  // ---- result select
  logic [63:0] op_res;

  always_comb begin
    op_res = prod;
    if (is_div) begin
      op_res = {rem, quo};
    end
`ifdef MDU_MADD_EN
    if (is_acc) begin
      op_res = is_sub ? ({hi, lo} - prod)
                      : ({hi, lo} + prod);
    end
`endif
  end

  // ---- control
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    res_nx   = res;
    hi_nx    = hi;
    lo_nx    = lo;
    unique case (state)
      IDLE: begin
        if (start) begin
          res_nx   = op_res;
          cnt_nx   = is_div ? DIV_LD : MUL_LD;
          state_nx = RUN;
        end else if (~exc_flush) begin
          if (mthilo == 2'b01) begin
            lo_nx = rs_data;
          end else if (mthilo == 2'b11) begin
            hi_nx = rs_data;
          end
        end
      end
      RUN: begin
        if (cnt == '0) begin
          hi_nx    = res[63:32];
          lo_nx    = res[31:0];
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      res   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      res   <= res_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
    end
  end

  assign busy = (state == RUN);

  always_comb begin
    hilo_out = '0;
    unique case (1'b1)
      (mfhilo == 2'b01): hilo_out = lo;
      (mfhilo == 2'b10): hilo_out = hi;
      default:           hilo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed + random bench for mdu_hilo against
// an arithmetic reference model of HI/LO and operation latency.
module tb_mdu_hilo;

  localparam int NM = 5;
  localparam int ND = 10;

  logic        clk;
  logic        rst_n;
  logic [3:0]  mdu_op;
  logic [1:0]  mthilo;
  logic [1:0]  mfhilo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        exc_flush;
  logic        busy;
  logic [31:0] hilo_out;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_hilo #(
    .MULT_CYCLES(NM),
    .DIV_CYCLES (ND)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdu_op   (mdu_op),
    .mthilo   (mthilo),
    .mfhilo   (mfhilo),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .exc_flush(exc_flush),
    .busy     (busy),
    .hilo_out (hilo_out),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_bad;

  // reference model state
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [63:0] m_pend;
  int          m_rem;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit op_ok(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1) && (op <= 4'd8);
`else
    return (op >= 4'd1) && (op <= 4'd4);
`endif
  endfunction

  function automatic logic [63:0] model_res(
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] acc);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] ps;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ps = 64'(sa * sb);
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3, 4'd4: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op == 4'd3) begin
          q = sa / sb;
          r = sa % sb;
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {r[31:0], q[31:0]};
      end
      4'd5: return acc + ps;
      4'd6: return acc + pu;
      4'd7: return acc - ps;
      4'd8: return acc - pu;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_out(input logic [1:0] mf);
    if (mf == 2'b01) return m_lo;
    if (mf == 2'b10) return m_hi;
    return 32'd0;
  endfunction

  task automatic check_all();
    check("busy", 64'(busy), 64'(m_rem > 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("hilo_out", 64'(hilo_out), 64'(exp_out(mfhilo)));
  endtask

  // Called at negedge: drive, advance model one edge, sample.
  task automatic cyc(input logic [3:0]  op,
                     input logic [1:0]  mt,
                     input logic [1:0]  mf,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic        fl);
    mdu_op    = op;
    mthilo    = mt;
    mfhilo    = mf;
    rs_data   = a;
    rt_data   = b;
    exc_flush = fl;
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = m_pend;
    end else if (!fl && op_ok(op)) begin
      m_pend = model_res(op, a, b, {m_hi, m_lo});
      m_rem  = (op == 4'd3 || op == 4'd4) ? ND : NM;
    end else if (!fl) begin
      if (mt == 2'b01) m_lo = a;
      else if (mt == 2'b11) m_hi = a;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(4'd0, 2'b00, 2'b01, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run_op(input logic [3:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        fl,
                        output int         nb);
    cyc(op, 2'b00, 2'b10, a, b, fl);
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      nb++;
      cyc(4'd0, 2'b00, 2'b10, 32'd0, 32'd0, 1'b0);
    end
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  int nb;

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    m_hi      = '0;
    m_lo      = '0;
    m_pend    = '0;
    m_rem     = 0;
    rst_n     = 1'b0;
    mdu_op    = '0;
    mthilo    = '0;
    mfhilo    = 2'b10;
    rs_data   = '0;
    rt_data   = '0;
    exc_flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hilo_out", 64'(hilo_out), 64'd0);
    rst_n = 1'b1;
    idle(1);

    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, nb);
    check("mult_cycles", 64'(nb), 64'(NM));
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);

    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, nb);
    check("multu_hi", 64'(hi), 64'd1);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, nb);
    check("div_cycles", 64'(nb), 64'(ND));
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    run_op(4'd4, 32'd7, 32'd0, 1'b0, nb);
    check("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("divu0_hi", 64'(hi), 64'd7);

    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);

    cyc(4'd0, 2'b11, 2'b10, 32'd1, 32'd0, 1'b0);
    cyc(4'd0, 2'b01, 2'b01, 32'd2, 32'd0, 1'b0);
    run_op(4'd5, 32'd3, 32'd4, 1'b0, nb);
`ifdef MDU_MADD_EN
    check("madd_cycles", 64'(nb), 64'(NM));
    check("madd_hi", 64'(hi), 64'd1);
    check("madd_lo", 64'(lo), 64'd14);
`else
    check("madd_cycles", 64'(nb), 64'd0);
    check("madd_hi", 64'(hi), 64'd1);
    check("madd_lo", 64'(lo), 64'd2);
`endif

    // flushed start: nothing happens, MT in same slot dropped too
    cyc(4'd1, 2'b11, 2'b10, 32'd9, 32'd9, 1'b1);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hi", 64'(hi), 64'd1);

    // flush mid-run does not cancel
    cyc(4'd2, 2'b00, 2'b10, 32'd6, 32'd7, 1'b0);
    cyc(4'd0, 2'b00, 2'b10, 32'd0, 32'd0, 1'b1);
    idle(NM);
    check("flushrun_lo", 64'(lo), 64'd42);

    // MT+op same cycle: op wins
    cyc(4'd2, 2'b11, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("run_old_hi", 64'(hilo_out), 64'd0);
    idle(NM);
    mfhilo = 2'b10;
    #1;
    check("run_new_hi", 64'(hilo_out), 64'hFFFF_FFFE);

    // reset during DIV
    cyc(4'd4, 2'b00, 2'b01, 32'd100, 32'd3, 1'b0);
    idle(2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    m_hi  = '0;
    m_lo  = '0;
    m_rem = 0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(ND + 2);
    check("arst_nocommit", 64'(lo), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 2) == 0) ? 4'd0
            : 4'($urandom_range(0, 15)),
          2'($urandom()), 2'($urandom()),
          rnd_val(), rnd_val(),
          ($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
